// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit ripple adder slice.
// The slice is reused once per nibble, LSB first, with a registered carry between passes.

module fa1 (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module FA4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;

    assign c[0] = c_i;
    assign c_o  = c[4];

    fa1 u_fa [3:0] (
        .a_i (a_i),
        .b_i (b_i),
        .c_i (c[3:0]),
        .s_o (s_o),
        .c_o (c[4:1])
    );
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    input  logic             op_sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             ovf_o,
    output logic             busy_o
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cy_q, cy_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] b_eff;
    logic [3:0]       fa_s;
    logic             fa_c;

    // Subtract is a + ~b + 1; the +1 rides in on the initial carry.
    assign b_eff = op_sub_i ? ~b_i : b_i;

    FA4b u_fa4 (
        .a_i (a_q[3:0]),
        .b_i (b_q[3:0]),
        .c_i (cy_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            cy_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            cy_q    <= cy_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sr_d       = sr_q;
        sum_d      = sum_q;
        k_d        = k_q;
        cy_d       = cy_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        ov_d       = ov_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b1;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_eff;
                    cy_d    = op_sub_i | c_in_i;
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_d = {fa_s, sr_q[WIDTH-1:4]};
                cy_d = fa_c;
                a_d  = {4'h0, a_q[WIDTH-1:4]};
                b_d  = {4'h0, b_q[WIDTH-1:4]};
                k_d  = k_q + KW'(1);
                // Last pass: the slice output is the top nibble, so overflow is known now.
                if (k_q == K_LAST) begin
                    sum_d   = {fa_s, sr_q[WIDTH-1:4]};
                    cout_d  = fa_c;
                    ovf_d   = (a_msb_q == b_msb_q) && (fa_s[3] != a_msb_q);
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid_o = ov_q;
    assign sum_o       = sum_q;
    assign c_out_o     = cout_q;
    assign ovf_o       = ovf_q;
endmodule
